// File: rtl/covox_pwm_dac.sv
// rtl/covox_pwm_dac.sv - covox byte capture, beeper/tape mixer and 1-bit PWM audio output
//
// Optional build macro: COVOX_SIGMA_DELTA_EN
//   undefined : fixed-period PWM; the mix is latched once per period.
//   defined   : first-order sigma-delta; the mix feeds an accumulator every cycle.

module covox_pwm_dac #(
  parameter int          PWM_BITS    = 8,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned BEEP_LEVEL  = 64,
  parameter int unsigned TAPE_LEVEL  = 16
) (
  input  logic       cpu_clock,
  input  logic       reset,
  input  logic       covox_wr,
  input  logic [7:0] d,
  input  logic       beeper,
  input  logic       tapeout,
  output logic       pwm_out,
  output logic       sample_strobe,
  output logic [7:0] sample
);

  // The mix needs two guard bits: an 8-bit sample plus both levels can exceed full scale.
  localparam int             MW      = PWM_BITS + 2;
  localparam logic [MW-1:0]  MIX_MAX = MW'((64'd1 << PWM_BITS) - 64'd1);

  // Synchronizer chains; index SYNC_STAGES-1 is the stage the rest of the design uses.
  logic [SYNC_STAGES-1:0]      r_wr_sync;
  logic [SYNC_STAGES-1:0][7:0] r_d_sync;
  logic [SYNC_STAGES-1:0]      r_beep_sync;
  logic [SYNC_STAGES-1:0]      r_tape_sync;

  logic       w_cs;
  logic [7:0] w_ds;
  logic       w_bs;
  logic       w_ts;

  logic       r_cs_prev;
  logic [7:0] r_d_hold;
  logic [7:0] r_sample;
  logic       r_strobe;
  logic       w_fall;

  logic [MW-1:0]       w_sample_ext;
  logic [MW-1:0]       w_m;
  logic [PWM_BITS-1:0] w_mix;

  assign w_cs = r_wr_sync[SYNC_STAGES-1];
  assign w_ds = r_d_sync[SYNC_STAGES-1];
  assign w_bs = r_beep_sync[SYNC_STAGES-1];
  assign w_ts = r_tape_sync[SYNC_STAGES-1];

  // Shift every asynchronous input through its own equal-depth chain so data and strobe stay aligned.
  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      r_wr_sync   <= '0;
      r_d_sync    <= '0;
      r_beep_sync <= '0;
      r_tape_sync <= '0;
    end else begin
      r_wr_sync   <= {r_wr_sync[SYNC_STAGES-2:0], covox_wr};
      r_d_sync    <= {r_d_sync[SYNC_STAGES-2:0], d};
      r_beep_sync <= {r_beep_sync[SYNC_STAGES-2:0], beeper};
      r_tape_sync <= {r_tape_sync[SYNC_STAGES-2:0], tapeout};
    end
  end

  // The byte is committed on the falling edge of the strobe, using the data seen while it was high.
  assign w_fall = r_cs_prev & ~w_cs;

  // Track the bus while the strobe is high and publish the held byte when the strobe drops.
  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      r_cs_prev <= 1'b0;
      r_d_hold  <= '0;
      r_sample  <= '0;
      r_strobe  <= 1'b0;
    end else begin
      r_cs_prev <= w_cs;
      if (w_cs) begin
        r_d_hold <= w_ds;
      end
      if (w_fall) begin
        r_sample <= r_d_hold;
      end
      r_strobe <= w_fall;
    end
  end

  // Left-align the byte into the PWM range, add the beeper/tape levels and clip at full scale.
  assign w_sample_ext = MW'(r_sample) << (PWM_BITS - 8);
  assign w_m          = w_sample_ext
                      + (w_bs ? MW'(BEEP_LEVEL) : MW'(0))
                      + (w_ts ? MW'(TAPE_LEVEL) : MW'(0));
  assign w_mix        = (w_m > MIX_MAX) ? {PWM_BITS{1'b1}} : w_m[PWM_BITS-1:0];

`ifdef COVOX_SIGMA_DELTA_EN

  // Top bit of the accumulator is the carry of the latest addition and doubles as the output bit.
  logic [PWM_BITS:0] r_acc;
  logic [PWM_BITS:0] w_acc_next;

  assign w_acc_next = {1'b0, r_acc[PWM_BITS-1:0]} + {1'b0, w_mix};

  // Accumulate the mix every cycle; the overflow density equals mix / 2^PWM_BITS.
  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_next;
    end
  end

  assign pwm_out = r_acc[PWM_BITS];

`else

  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_pwm;
  logic                w_reload;
  logic [PWM_BITS-1:0] w_cnt_next;
  logic [PWM_BITS-1:0] w_duty_next;

  // Duty only changes as the counter wraps, so every period is built from a single value.
  assign w_reload    = (r_cnt == {PWM_BITS{1'b1}});
  assign w_cnt_next  = r_cnt + PWM_BITS'(1);
  assign w_duty_next = w_reload ? w_mix : r_duty;

  // Free-running period counter, period-latched duty and registered comparator output.
  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_pwm  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_duty <= w_duty_next;
      r_pwm  <= (w_cnt_next < w_duty_next);
    end
  end

  assign pwm_out = r_pwm;

`endif

  assign sample_strobe = r_strobe;
  assign sample        = r_sample;

endmodule

// File: tb/tb_covox_pwm_dac.sv
// tb/tb_covox_pwm_dac.sv - self-checking bench for covox_pwm_dac
`timescale 1ns/1ps

module tb_covox_pwm_dac;

  localparam int PWM_BITS    = 8;
  localparam int SYNC_STAGES = 2;
  localparam int BEEP_LEVEL  = 64;
  localparam int TAPE_LEVEL  = 16;
  localparam int PERIOD      = 1 << PWM_BITS;

  logic       cpu_clock = 1'b0;
  logic       reset     = 1'b1;
  logic       covox_wr  = 1'b0;
  logic [7:0] d         = 8'h00;
  logic       beeper    = 1'b0;
  logic       tapeout   = 1'b0;
  logic       pwm_out;
  logic       sample_strobe;
  logic [7:0] sample;

  int checks = 0;
  int passed = 0;

  covox_pwm_dac #(
    .PWM_BITS   (PWM_BITS),
    .SYNC_STAGES(SYNC_STAGES),
    .BEEP_LEVEL (BEEP_LEVEL),
    .TAPE_LEVEL (TAPE_LEVEL)
  ) dut (
    .cpu_clock    (cpu_clock),
    .reset        (reset),
    .covox_wr     (covox_wr),
    .d            (d),
    .beeper       (beeper),
    .tapeout      (tapeout),
    .pwm_out      (pwm_out),
    .sample_strobe(sample_strobe),
    .sample       (sample)
  );

  always #5 cpu_clock = ~cpu_clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: input history per clock edge plus arithmetic rules.
  int         edge_n   = 0;
  int         last_rst = -1;
  bit         model_valid = 0;
  logic       h_wr [16];
  logic [7:0] h_d  [16];
  logic       h_b  [16];
  logic       h_t  [16];
  logic [7:0] exp_sample = 0;
  logic       exp_strobe = 0;
  logic       exp_pwm    = 0;
  int         exp_duty   = 0;
  longint     sd_total   = 0;

  function automatic int mix_of(input int s, input logic b, input logic t);
    int m;
    m = s * (1 << (PWM_BITS - 8)) + (b ? BEEP_LEVEL : 0) + (t ? TAPE_LEVEL : 0);
    return (m > PERIOD - 1) ? PERIOD - 1 : m;
  endfunction

  function automatic bit seen(input int j);
    return (j >= 0) && (j > last_rst);
  endfunction

  function automatic int phase();
    return (edge_n - last_rst) % PERIOD;
  endfunction

  always @(posedge cpu_clock) begin
    int mv;
    logic bs, ts, fall;
    edge_n++;
    h_wr[edge_n % 16] = covox_wr;
    h_d [edge_n % 16] = d;
    h_b [edge_n % 16] = beeper;
    h_t [edge_n % 16] = tapeout;
    if (reset) begin
      last_rst    = edge_n;
      model_valid = 1;
      exp_sample  = 0;
      exp_strobe  = 0;
      exp_pwm     = 0;
      exp_duty    = 0;
      sd_total    = 0;
    end else if (model_valid) begin
      bs   = seen(edge_n - SYNC_STAGES) ? h_b[(edge_n - SYNC_STAGES) % 16] : 1'b0;
      ts   = seen(edge_n - SYNC_STAGES) ? h_t[(edge_n - SYNC_STAGES) % 16] : 1'b0;
      mv   = mix_of(int'(exp_sample), bs, ts);
      fall = seen(edge_n - SYNC_STAGES - 1)
             && h_wr[(edge_n - SYNC_STAGES - 1) % 16]
             && !h_wr[(edge_n - SYNC_STAGES) % 16];
`ifdef COVOX_SIGMA_DELTA_EN
      exp_pwm  = ((sd_total + mv) / PERIOD) != (sd_total / PERIOD);
      sd_total = sd_total + mv;
`else
      if (phase() == 0) exp_duty = mv;
      exp_pwm = (phase() < exp_duty);
`endif
      exp_strobe = fall;
      if (fall) exp_sample = h_d[(edge_n - SYNC_STAGES - 1) % 16];
    end
  end

  always @(negedge cpu_clock) begin
    if (model_valid) begin
      check("pwm_out", int'(pwm_out), int'(exp_pwm));
      check("sample_strobe", int'(sample_strobe), int'(exp_strobe));
      check("sample", int'(sample), int'(exp_sample));
    end
  end

  task automatic tick();
    @(posedge cpu_clock);
    #1;
  endtask

  task automatic wait_phase(input int p);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      if (phase() == p) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("wait_phase_bound", int'(ok), 1);
  endtask

  task automatic count_period(output int ones);
    wait_phase(0);
    ones = 0;
    for (int i = 0; i < PERIOD; i++) begin
      ones += int'(pwm_out);
      tick();
    end
  endtask

  task automatic write_byte(input logic [7:0] v);
    d = v;
    covox_wr = 1'b1;
    repeat (4) tick();
    covox_wr = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    int ones;
    int strobes;
    bit ok;
`ifdef COVOX_SIGMA_DELTA_EN
    logic cap [512];
    int adj;
`endif

    // Reset held with the strobe active and all-ones data.
    reset = 1'b1;
    covox_wr = 1'b1;
    d = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_pwm", int'(pwm_out), 0);
      check("reset_sample", int'(sample), 0);
      check("reset_strobe", int'(sample_strobe), 0);
    end
    covox_wr = 1'b0;
    d = 8'h00;
    reset = 1'b0;

`ifdef COVOX_SIGMA_DELTA_EN
    ones = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      ones += int'(pwm_out);
    end
    check("sd_release_ones", ones, 0);

    write_byte(8'h40);
    check("sd_sample_40", int'(sample), 8'h40);
    for (int i = 0; i < 512; i++) begin
      tick();
      cap[i] = pwm_out;
    end
    for (int w = 0; w <= 256; w += 32) begin
      ones = 0;
      for (int i = 0; i < 256; i++) ones += int'(cap[w + i]);
      check("sd_window_64", ones, 64);
    end
    adj = 0;
    for (int i = 1; i < 512; i++) if (cap[i] && cap[i-1]) adj++;
    check("sd_adjacent_ones", adj, 0);

    beeper = 1'b1;
    tapeout = 1'b1;
    write_byte(8'hF0);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      ones += int'(pwm_out);
    end
    check("sd_saturated_255", ones, 255);
`else
    // One full period after release stays silent.
    ones = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      ones += int'(pwm_out);
    end
    check("release_ones", ones, 0);

    // Capture latency of a single write.
    d = 8'h80;
    covox_wr = 1'b1;
    repeat (4) tick();
    covox_wr = 1'b0;
    tick();
    check("lat_strobe_k", int'(sample_strobe), 0);
    tick();
    check("lat_strobe_k1", int'(sample_strobe), 0);
    check("lat_sample_k1", int'(sample), 0);
    tick();
    check("lat_strobe_k2", int'(sample_strobe), 1);
    check("lat_sample_k2", int'(sample), 8'h80);
    tick();
    check("lat_strobe_k3", int'(sample_strobe), 0);
    count_period(ones);
    check("duty_80", ones, 128);

    // Mixer: beeper alone, tape alone, sum, saturation.
    beeper = 1'b1;
    write_byte(8'h00);
    count_period(ones);
    check("beeper_only", ones, 64);
    beeper = 1'b0;
    tapeout = 1'b1;
    write_byte(8'h00);
    count_period(ones);
    check("tape_only", ones, 16);
    beeper = 1'b1;
    write_byte(8'h20);
    count_period(ones);
    check("mix_20_b_t", ones, 112);
    write_byte(8'hF0);
    count_period(ones);
    check("saturate_F0", ones, 255);
    beeper = 1'b0;
    tapeout = 1'b0;

    // Back-to-back writes separated by two low cycles.
    strobes = 0;
    d = 8'h11;
    covox_wr = 1'b1;
    repeat (3) begin tick(); strobes += int'(sample_strobe); end
    covox_wr = 1'b0;
    repeat (2) begin tick(); strobes += int'(sample_strobe); end
    d = 8'h22;
    covox_wr = 1'b1;
    repeat (3) begin tick(); strobes += int'(sample_strobe); end
    covox_wr = 1'b0;
    repeat (6) begin tick(); strobes += int'(sample_strobe); end
    check("b2b_strobes", strobes, 2);
    check("b2b_sample", int'(sample), 8'h22);

    // Sample update coinciding with the period reload.
    write_byte(8'h10);
    count_period(ones);
    check("pre_coincide_16", ones, 16);
    wait_phase(240);
    d = 8'h40;
    covox_wr = 1'b1;
    wait_phase(253);
    covox_wr = 1'b0;
    tick();
    wait_phase(0);
    check("coincide_sample", int'(sample), 8'h40);
    check("coincide_strobe", int'(sample_strobe), 1);
    count_period(ones);
    check("coincide_old_16", ones, 16);
    count_period(ones);
    check("coincide_new_64", ones, 64);

    // Reset in the middle of a period with duty 200.
    write_byte(8'hC8);
    count_period(ones);
    check("duty_C8", ones, 200);
    wait_phase(100);
    reset = 1'b1;
    tick();
    check("midrst_pwm", int'(pwm_out), 0);
    check("midrst_sample", int'(sample), 0);
    reset = 1'b0;
    write_byte(8'hC8);
    ones = 0;
    ok = 0;
    for (int i = 0; i < PERIOD + 4; i++) begin
      tick();
      if (phase() == 0) begin
        ok = 1;
        break;
      end
      ones += int'(pwm_out);
    end
    check("midrst_reload_seen", int'(ok), 1);
    check("midrst_partial_ones", ones, 0);
    count_period(ones);
    check("midrst_after_reload", ones, 200);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
